// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared state encoding, difficulty codes and LFSR taps for the
//             round controller.
//  Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESULT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] c_diff_easy   = 2'd0;
    localparam logic [1:0] c_diff_medium = 2'd1;
    localparam logic [1:0] c_diff_hard   = 2'd2;

    // Fibonacci taps 8,6,5,4 expressed as a mask over q[7:0]
    localparam logic [7:0] c_lfsr_taps = 8'b1011_1000;

    function automatic logic [1:0] clamp_difficulty(input logic [1:0] d);
        return (d > c_diff_hard) ? c_diff_hard : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr8
//  Purpose  : Free-running 8-bit Fibonacci LFSR used for target selection.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= seed;
        end else begin
            q <= {q[6:0], ^(q & c_lfsr_taps)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
//  Module   : round_controller
//  Purpose  : Game round sequencer driving the reaction timer; picks targets,
//             scores hits/misses and ends the game after NUM_ROUNDS rounds.
//  Revision : 1.0  initial release
// ============================================================================
module round_controller
    import game_pkg::*;
#(
    parameter int          N_TARGETS  = 4,
    parameter int          NUM_ROUNDS = 10,
    parameter logic [11:0] END_VALUE  = 12'd100,
    parameter int          RESULT_CYC = 25000,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           difficulty_in,
    input  logic [N_TARGETS-1:0] buttons,
    input  logic [11:0]          timer_value,
    input  logic                 end_reached,
    output logic                 timer_reset,
    output logic                 timer_enable,
    output logic [1:0]           difficulty,
    output logic [11:0]          end_value,
    output logic [N_TARGETS-1:0] target_led,
    output logic                 hit,
    output logic                 miss,
    output logic [7:0]           score,
    output logic [7:0]           round_num,
    output logic [11:0]          reaction_time,
    output logic                 game_over
);

    localparam int IDX_W = $clog2(N_TARGETS);
    localparam int CNT_W = $clog2(RESULT_CYC + 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_target;
    logic [CNT_W-1:0]     r_cnt;
    logic [N_TARGETS-1:0] r_buttons_q;

    logic [7:0]           w_lfsr;
    logic                 w_unused_lfsr;
    logic [N_TARGETS-1:0] w_edges;
    logic [N_TARGETS-1:0] w_target_oh;
    logic                 w_press_any;
    logic                 w_press_hit;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    // Only the low index bits select the target; the rest just keep mixing.
    assign w_unused_lfsr = ^w_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buttons_q <= '0;
        end else begin
            r_buttons_q <= buttons;
        end
    end

    assign w_edges     = buttons & ~r_buttons_q;
    assign w_target_oh = {{(N_TARGETS-1){1'b0}}, 1'b1} << r_target;
    assign w_press_any = |w_edges;
    assign w_press_hit = (w_edges == w_target_oh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_target      <= '0;
            r_cnt         <= '0;
            timer_reset   <= 1'b0;
            timer_enable  <= 1'b0;
            difficulty    <= c_diff_easy;
            end_value     <= END_VALUE;
            target_led    <= '0;
            hit           <= 1'b0;
            miss          <= 1'b0;
            score         <= '0;
            round_num     <= '0;
            reaction_time <= '0;
            game_over     <= 1'b0;
        end else begin
            timer_reset <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_ARM;
                        r_target      <= w_lfsr[IDX_W-1:0];
                        difficulty    <= clamp_difficulty(difficulty_in);
                        score         <= '0;
                        round_num     <= '0;
                        reaction_time <= '0;
                        game_over     <= 1'b0;
                        timer_reset   <= 1'b1;
                        timer_enable  <= 1'b0;
                    end
                end
                ST_ARM: begin
                    r_state      <= ST_WAIT;
                    timer_enable <= 1'b1;
                    target_led   <= w_target_oh;
                end
                ST_WAIT: begin
                    // A clean target edge wins over a simultaneous timeout.
                    if (w_press_any || end_reached) begin
                        r_state      <= ST_RESULT;
                        r_cnt        <= '0;
                        timer_enable <= 1'b0;
                        target_led   <= '0;
                        round_num    <= round_num + 8'd1;
                        if (w_press_hit) begin
                            hit           <= 1'b1;
                            reaction_time <= timer_value;
                            if (score != 8'hFF) begin
                                score <= score + 8'd1;
                            end
                        end else begin
                            miss <= 1'b1;
                        end
                    end
                end
                ST_RESULT: begin
                    if (r_cnt == CNT_W'(RESULT_CYC - 1)) begin
                        if (round_num == 8'(NUM_ROUNDS)) begin
                            r_state   <= ST_DONE;
                            game_over <= 1'b1;
                        end else begin
                            r_state     <= ST_ARM;
                            r_target    <= w_lfsr[IDX_W-1:0];
                            timer_reset <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_controller
//  Purpose  : Self-checking bench for round_controller against a round-level
//             reference model with a software LFSR.
//  Revision : 1.0  initial release
// ============================================================================
module tb_round_controller;

    localparam int          N_TARGETS  = 4;
    localparam int          NUM_ROUNDS = 3;
    localparam logic [11:0] END_VALUE  = 12'd100;
    localparam int          RESULT_CYC = 3;
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;

    localparam int K_HIT     = 0;
    localparam int K_WRONG   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_HIT_END = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [1:0]           difficulty_in;
    logic [N_TARGETS-1:0] buttons;
    logic [11:0]          timer_value;
    logic                 end_reached;
    logic                 timer_reset;
    logic                 timer_enable;
    logic [1:0]           difficulty;
    logic [11:0]          end_value;
    logic [N_TARGETS-1:0] target_led;
    logic                 hit;
    logic                 miss;
    logic [7:0]           score;
    logic [7:0]           round_num;
    logic [11:0]          reaction_time;
    logic                 game_over;

    round_controller #(
        .N_TARGETS  (N_TARGETS),
        .NUM_ROUNDS (NUM_ROUNDS),
        .END_VALUE  (END_VALUE),
        .RESULT_CYC (RESULT_CYC),
        .LFSR_SEED  (LFSR_SEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .difficulty_in (difficulty_in),
        .buttons       (buttons),
        .timer_value   (timer_value),
        .end_reached   (end_reached),
        .timer_reset   (timer_reset),
        .timer_enable  (timer_enable),
        .difficulty    (difficulty),
        .end_value     (end_value),
        .target_led    (target_led),
        .hit           (hit),
        .miss          (miss),
        .score         (score),
        .round_num     (round_num),
        .reaction_time (reaction_time),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state: software LFSR plus per-game score bookkeeping.
    int m_lfsr = int'(LFSR_SEED);
    int tgt;
    int exp_score;
    int exp_round;
    int exp_rt;
    int exp_diff;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset) m_lfsr = int'(LFSR_SEED);
        else       m_lfsr = lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic start_game(input logic [1:0] diff);
        start         = 1'b1;
        difficulty_in = diff;
        tgt           = m_lfsr % N_TARGETS;
        step();
        start     = 1'b0;
        exp_score = 0;
        exp_round = 0;
        exp_rt    = 0;
        exp_diff  = (diff == 2'd3) ? 2 : int'(diff);
        chk("arm_timer_reset", 32'(timer_reset), 32'd1);
        chk("arm_timer_enable", 32'(timer_enable), 32'd0);
        chk("arm_score", 32'(score), 32'd0);
        chk("arm_round", 32'(round_num), 32'd0);
        chk("arm_rt", 32'(reaction_time), 32'd0);
        chk("arm_diff", 32'(difficulty), 32'(exp_diff));
        chk("arm_game_over", 32'(game_over), 32'd0);
        step();
        chk("wait_timer_enable", 32'(timer_enable), 32'd1);
        chk("wait_timer_reset", 32'(timer_reset), 32'd0);
        chk("wait_led", 32'(target_led), 32'(1 << tgt));
    endtask

    task automatic play_round(input int kind, input int w, input logic [11:0] tv,
                              input bit also_target, input bit poke_start);
        int  other;
        bit  exp_hit;
        logic [N_TARGETS-1:0] tb_bit;
        logic [N_TARGETS-1:0] ob_bit;
        for (int i = 0; i < w; i++) begin
            timer_value = 12'(i);
            start       = poke_start && (i == 0);
            step();
            start = 1'b0;
            chk("idle_hit", 32'(hit), 32'd0);
            chk("idle_miss", 32'(miss), 32'd0);
            chk("idle_timer_reset", 32'(timer_reset), 32'd0);
            chk("idle_timer_enable", 32'(timer_enable), 32'd1);
        end
        other  = (tgt + 1 + int'($urandom_range(0, N_TARGETS - 2))) % N_TARGETS;
        tb_bit = N_TARGETS'(1 << tgt);
        ob_bit = N_TARGETS'(1 << other);
        timer_value = tv;
        case (kind)
            K_HIT:     begin buttons = tb_bit; exp_hit = 1'b1; end
            K_WRONG:   begin buttons = ob_bit | (also_target ? tb_bit : '0); exp_hit = 1'b0; end
            K_TIMEOUT: begin end_reached = 1'b1; exp_hit = 1'b0; end
            default:   begin buttons = tb_bit; end_reached = 1'b1; exp_hit = 1'b1; end
        endcase
        step();
        if (exp_hit) begin
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
            exp_rt    = int'(tv);
        end
        exp_round++;
        difficulty_in = 2'($urandom);
        buttons       = '0;
        end_reached   = 1'b0;
        chk("evt_hit", 32'(hit), 32'(exp_hit));
        chk("evt_miss", 32'(miss), 32'(!exp_hit));
        chk("evt_score", 32'(score), 32'(exp_score));
        chk("evt_round", 32'(round_num), 32'(exp_round));
        chk("evt_rt", 32'(reaction_time), 32'(exp_rt));
        chk("evt_led", 32'(target_led), 32'd0);
        chk("evt_timer_enable", 32'(timer_enable), 32'd0);
        for (int i = 0; i < RESULT_CYC - 1; i++) begin
            step();
            chk("res_hit", 32'(hit), 32'd0);
            chk("res_miss", 32'(miss), 32'd0);
            chk("res_diff", 32'(difficulty), 32'(exp_diff));
        end
        other = m_lfsr % N_TARGETS;
        step();
        if (exp_round == NUM_ROUNDS) begin
            chk("done_game_over", 32'(game_over), 32'd1);
            chk("done_timer_reset", 32'(timer_reset), 32'd0);
            chk("done_score", 32'(score), 32'(exp_score));
        end else begin
            tgt = other;
            chk("rearm_timer_reset", 32'(timer_reset), 32'd1);
            chk("rearm_game_over", 32'(game_over), 32'd0);
            step();
            chk("rearm_timer_enable", 32'(timer_enable), 32'd1);
            chk("rearm_led", 32'(target_led), 32'(1 << tgt));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        difficulty_in = 2'd0;
        buttons       = '0;
        timer_value   = '0;
        end_reached   = 1'b0;
        step();
        step();
        chk("rst_end_value", 32'(end_value), 32'(END_VALUE));
        chk("rst_led", 32'(target_led), 32'd0);
        chk("rst_timer_enable", 32'(timer_enable), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_start", 32'(timer_reset), 32'd0);

        // Directed game: hit at 37, timeout, target+other press.
        start_game(2'd1);
        play_round(K_HIT, 3, 12'd37, 1'b0, 1'b0);
        play_round(K_TIMEOUT, 4, 12'd0, 1'b0, 1'b0);
        play_round(K_WRONG, 2, 12'd5, 1'b1, 1'b0);
        step();
        chk("done_hold_game_over", 32'(game_over), 32'd1);
        chk("done_hold_round", 32'(round_num), 32'(NUM_ROUNDS));
        chk("done_hold_rt", 32'(reaction_time), 32'd37);

        // All-hit game, including a press coinciding with the timeout.
        start_game(2'd3);
        play_round(K_HIT_END, 1, 12'd99, 1'b0, 1'b0);
        play_round(K_HIT, 0, 12'd12, 1'b0, 1'b0);
        play_round(K_HIT, 5, 12'd250, 1'b0, 1'b0);
        chk("all_hit_score", 32'(score), 32'd3);

        // Buttons held from before the round never count; start in WAIT ignored.
        buttons = '1;
        start_game(2'd2);
        buttons = '1;
        play_round(K_TIMEOUT, 3, 12'd7, 1'b0, 1'b1);
        play_round(K_HIT, 2, 12'd44, 1'b0, 1'b1);
        play_round(K_WRONG, 1, 12'd9, 1'b0, 1'b0);

        for (int g = 0; g < 5; g++) begin
            start_game(2'($urandom));
            for (int r = 0; r < NUM_ROUNDS; r++) begin
                play_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                           12'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        // Reset in the middle of WAIT.
        start_game(2'd1);
        step();
        reset = 1'b1;
        step();
        chk("midrst_led", 32'(target_led), 32'd0);
        chk("midrst_timer_enable", 32'(timer_enable), 32'd0);
        chk("midrst_score", 32'(score), 32'd0);
        chk("midrst_end_value", 32'(end_value), 32'(END_VALUE));
        reset = 1'b0;
        step();
        chk("midrst_idle", 32'(timer_reset), 32'd0);
        start_game(2'd0);
        play_round(K_HIT, 1, 12'd3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
